// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine: SD/SDIO CMD-line engine.
// Sends a 48-bit command frame with CRC7, then optionally receives a short or
// long response. The response path checks CRC, the end bit and the command
// index, and can wait for the card to release DAT0 after an R1b response.
module sd_cmd_engine #(
    parameter int IDLE_CYCLES  = 8,
    parameter int RESP_TIMEOUT = 64,
    parameter int BUSY_TIMEOUT = 65535
) (
    input  logic         sd_clk,
    input  logic         rst,
    input  logic         cmd_start,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_arg,
    input  logic [1:0]   resp_type,
    input  logic         chk_index,
    input  logic         busy_chk,
    input  logic         dat0_in,
    input  logic         cmd_in,
    output logic         cmd_oe,
    output logic         cmd_out,
    output logic         busy,
    output logic         done,
    output logic [5:0]   resp_index,
    output logic [127:0] resp,
    output logic         f_timeout,
    output logic         f_crc_fail,
    output logic         f_index_fail,
    output logic         f_busy_timeout
);

    // One counter serves every state, so it must hold the largest busy count.
    localparam int CW = $clog2(BUSY_TIMEOUT + RESP_TIMEOUT + IDLE_CYCLES + 200);
    localparam logic [CW-1:0] GAP_LAST  = CW'(IDLE_CYCLES - 1);
    localparam logic [CW-1:0] RSP_LAST  = CW'(RESP_TIMEOUT - 1);
    localparam logic [CW-1:0] BUSY_LAST = CW'(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_SEND, S_WAIT_RSP, S_RECV, S_BUSY, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [5:0]      idx_q, idx_d;
    logic [31:0]     arg_q, arg_d;
    logic [1:0]      rtype_q, rtype_d;
    logic            chk_idx_q, chk_idx_d;
    logic            bchk_q, bchk_d;
    logic [132:0]    rx_q, rx_d;
    logic [6:0]      crc_q, crc_d;
    logic            cmd_oe_q, cmd_oe_d;
    logic            cmd_out_q, cmd_out_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [127:0]    resp_q, resp_d;
    logic [5:0]      resp_index_q, resp_index_d;
    logic            f_timeout_q, f_timeout_d;
    logic            f_crc_q, f_crc_d;
    logic            f_index_q, f_index_d;
    logic            f_busy_q, f_busy_d;

    logic [39:0]     tx_hdr;
    logic [6:0]      tx_crc;
    logic [47:0]     tx_frame;
    logic [5:0]      tx_bit;
    logic [133:0]    fr;
    logic            is_long;
    logic            in_span;
    logic [CW-1:0]   rx_last;

    // Serial CRC7 step, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // Command frame built from the latched index and argument.
    always_comb begin
        tx_hdr = {2'b01, idx_q, arg_q};
        tx_crc = '0;
        for (int i = 39; i >= 0; i--) tx_crc = crc7_step(tx_crc, tx_hdr[i]);
        tx_frame = {tx_hdr, tx_crc, 1'b1};
        tx_bit   = 6'd47 - cnt_q[5:0];
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        arg_d        = arg_q;
        rtype_d      = rtype_q;
        chk_idx_d    = chk_idx_q;
        bchk_d       = bchk_q;
        rx_d         = rx_q;
        crc_d        = crc_q;
        cmd_out_d    = 1'b1;
        resp_d       = resp_q;
        resp_index_d = resp_index_q;
        f_timeout_d  = f_timeout_q;
        f_crc_d      = f_crc_q;
        f_index_d    = f_index_q;
        f_busy_d     = f_busy_q;
        // rx_q already holds every bit before the current one.
        fr           = {rx_q, cmd_in};
        is_long      = (rtype_q == 2'b10);
        rx_last      = is_long ? CW'(135) : CW'(47);
        // Short CRC covers the first 40 bits; long skips the 8-bit header.
        in_span      = is_long ? (cnt_q >= CW'(8) && cnt_q < CW'(128)) : (cnt_q < CW'(40));

        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    idx_d       = cmd_index;
                    arg_d       = cmd_arg;
                    rtype_d     = resp_type;
                    chk_idx_d   = chk_index;
                    bchk_d      = busy_chk;
                    f_timeout_d = 1'b0;
                    f_crc_d     = 1'b0;
                    f_index_d   = 1'b0;
                    f_busy_d    = 1'b0;
                    cnt_d       = '0;
                    state_d     = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cmd_out_d = tx_frame[47];
                    cnt_d     = CW'(1);
                    state_d   = S_SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SEND: begin
                if (cnt_q == CW'(48)) begin
                    cnt_d   = '0;
                    state_d = (rtype_q == 2'b00) ? S_DONE : S_WAIT_RSP;
                end else begin
                    cmd_out_d = tx_frame[tx_bit];
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            S_WAIT_RSP: begin
                if (!cmd_in) begin
                    // Start bit is frame bit 0 of the count; CRC of a 0 from
                    // reset state stays 0.
                    rx_d    = '0;
                    crc_d   = '0;
                    cnt_d   = CW'(1);
                    state_d = S_RECV;
                end else if (cnt_q == RSP_LAST) begin
                    f_timeout_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RECV: begin
                rx_d = {rx_q[131:0], cmd_in};
                if (in_span) crc_d = crc7_step(crc_q, cmd_in);
                if (cnt_q == rx_last) begin
                    if (!cmd_in || (crc_q != fr[7:1] && rtype_q != 2'b11))
                        f_crc_d = 1'b1;
                    if (is_long) begin
                        // Long frames carry the reserved field where the index sits.
                        resp_d       = fr[127:0];
                        resp_index_d = fr[133:128];
                        state_d      = S_DONE;
                    end else begin
                        resp_d       = {96'b0, fr[39:8]};
                        resp_index_d = fr[45:40];
                        if (chk_idx_q && fr[45:40] != idx_q) f_index_d = 1'b1;
                        cnt_d   = '0;
                        state_d = bchk_q ? S_BUSY : S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BUSY: begin
                // First two cycles after the end bit are a blanking window.
                if (cnt_q >= CW'(2) && dat0_in) begin
                    state_d = S_DONE;
                end else if (cnt_q == BUSY_LAST) begin
                    f_busy_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        cmd_oe_d = (state_d == S_SEND);
        busy_d   = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d   = (state_d == S_DONE);
    end

    // State and output registers; reset releases CMD immediately.
    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            arg_q        <= '0;
            rtype_q      <= '0;
            chk_idx_q    <= 1'b0;
            bchk_q       <= 1'b0;
            rx_q         <= '0;
            crc_q        <= '0;
            cmd_oe_q     <= 1'b0;
            cmd_out_q    <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            resp_q       <= '0;
            resp_index_q <= '0;
            f_timeout_q  <= 1'b0;
            f_crc_q      <= 1'b0;
            f_index_q    <= 1'b0;
            f_busy_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            arg_q        <= arg_d;
            rtype_q      <= rtype_d;
            chk_idx_q    <= chk_idx_d;
            bchk_q       <= bchk_d;
            rx_q         <= rx_d;
            crc_q        <= crc_d;
            cmd_oe_q     <= cmd_oe_d;
            cmd_out_q    <= cmd_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            resp_q       <= resp_d;
            resp_index_q <= resp_index_d;
            f_timeout_q  <= f_timeout_d;
            f_crc_q      <= f_crc_d;
            f_index_q    <= f_index_d;
            f_busy_q     <= f_busy_d;
        end
    end

    assign cmd_oe         = cmd_oe_q;
    assign cmd_out        = cmd_out_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign resp           = resp_q;
    assign resp_index     = resp_index_q;
    assign f_timeout      = f_timeout_q;
    assign f_crc_fail     = f_crc_q;
    assign f_index_fail   = f_index_q;
    assign f_busy_timeout = f_busy_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed bench for sd_cmd_engine: frame serialisation, response reception,
// error flags, busy wait, reset behaviour. A second instance with a short
// busy timeout shares all inputs.
module tb_sd_cmd_engine;

    localparam int N = 8;

    logic         sd_clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_start = 1'b0;
    logic [5:0]   cmd_index = '0;
    logic [31:0]  cmd_arg = '0;
    logic [1:0]   resp_type = '0;
    logic         chk_index = 1'b0;
    logic         busy_chk = 1'b0;
    logic         dat0_in = 1'b1;
    logic         cmd_in = 1'b1;
    logic         cmd_oe, cmd_out, busy, done;
    logic [5:0]   resp_index;
    logic [127:0] resp;
    logic         f_timeout, f_crc_fail, f_index_fail, f_busy_timeout;
    logic         bt_cmd_oe, bt_cmd_out, bt_busy, bt_done;
    logic [5:0]   bt_resp_index;
    logic [127:0] bt_resp;
    logic         bt_f_timeout, bt_f_crc_fail, bt_f_index_fail, bt_f_busy_timeout;
    logic [3:0]   flg;

    int checks = 0;
    int errors = 0;

    assign flg = {f_timeout, f_crc_fail, f_index_fail, f_busy_timeout};

    always #5 sd_clk = ~sd_clk;

    sd_cmd_engine #(.IDLE_CYCLES(N), .RESP_TIMEOUT(64), .BUSY_TIMEOUT(65535)) dut (
        .sd_clk(sd_clk), .rst(rst), .cmd_start(cmd_start), .cmd_index(cmd_index),
        .cmd_arg(cmd_arg), .resp_type(resp_type), .chk_index(chk_index),
        .busy_chk(busy_chk), .dat0_in(dat0_in), .cmd_in(cmd_in), .cmd_oe(cmd_oe),
        .cmd_out(cmd_out), .busy(busy), .done(done), .resp_index(resp_index),
        .resp(resp), .f_timeout(f_timeout), .f_crc_fail(f_crc_fail),
        .f_index_fail(f_index_fail), .f_busy_timeout(f_busy_timeout)
    );

    sd_cmd_engine #(.IDLE_CYCLES(N), .RESP_TIMEOUT(64), .BUSY_TIMEOUT(16)) dut_bt (
        .sd_clk(sd_clk), .rst(rst), .cmd_start(cmd_start), .cmd_index(cmd_index),
        .cmd_arg(cmd_arg), .resp_type(resp_type), .chk_index(chk_index),
        .busy_chk(busy_chk), .dat0_in(dat0_in), .cmd_in(cmd_in), .cmd_oe(bt_cmd_oe),
        .cmd_out(bt_cmd_out), .busy(bt_busy), .done(bt_done), .resp_index(bt_resp_index),
        .resp(bt_resp), .f_timeout(bt_f_timeout), .f_crc_fail(bt_f_crc_fail),
        .f_index_fail(bt_f_index_fail), .f_busy_timeout(bt_f_busy_timeout)
    );

    // Reference CRC7 (x^7+x^3+1, init 0) over the low n bits of d, MSB first.
    function automatic logic [6:0] crc7(input logic [119:0] d, input int n);
        logic [6:0] c;
        logic fb;
        c = '0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge sd_clk);
        #1;
    endtask

    // Runs one command from cycle 0. The card reply starts at cycle
    // N+49+rdelay; dat0 (busy_chk only) rises at S+48+dlow, never if dlow<0.
    // Returns the cycle done was seen (-1 on expiry), then steps one cycle.
    task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg,
                          input logic [1:0] rt, input logic chk, input logic bchk,
                          input logic [135:0] rep, input int rlen, input int rdelay,
                          input int dlow, input int ign_cyc, input logic watch_bt,
                          output logic [47:0] tx, output int dcyc,
                          output logic oe_bad, output logic busy_bad);
        int c;
        int s;
        s = N + 49 + rdelay;
        tx = '0; dcyc = -1; oe_bad = 1'b0; busy_bad = 1'b0;
        cmd_index = idx; cmd_arg = arg; resp_type = rt;
        chk_index = chk; busy_chk = bchk; cmd_start = 1'b1;
        c = 0;
        while (c < 3000) begin
            if (c > 0) begin
                cmd_start = (c == ign_cyc);
                if (c == ign_cyc) cmd_index = 6'h3F;
            end
            cmd_in  = (rlen > 0 && c >= s && c < s + rlen) ? rep[rlen - 1 - (c - s)] : 1'b1;
            dat0_in = !bchk || (dlow >= 0 && c >= s + 48 + dlow);
            tick();
            c++;
            if (c >= N + 1 && c <= N + 48) tx[N + 48 - c] = cmd_out;
            if (cmd_oe !== (c >= N + 1 && c <= N + 48)) oe_bad = 1'b1;
            if (watch_bt ? bt_done : done) begin
                dcyc = c;
                break;
            end
            if (busy !== 1'b1) busy_bad = 1'b1;
        end
        cmd_start = 1'b0;
        cmd_in = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (cmd_oe !== 1'b0) begin errors++; $display("FAIL rst_cmd_oe got %b exp 0", cmd_oe); end
        checks++; if (cmd_out !== 1'b1) begin errors++; $display("FAIL rst_cmd_out got %b exp 1", cmd_out); end
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rst_busy_done got %b exp 00", {busy, done}); end
        checks++; if (resp !== 128'h0 || resp_index !== 6'h0) begin errors++; $display("FAIL rst_resp got %h/%h exp 0/0", resp, resp_index); end
        checks++; if (flg !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b exp 0000", flg); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_no_resp();
        logic [47:0] tx; int dc; logic ob, bb;
        do_cmd(6'd0, 32'h0, 2'b00, 1'b0, 1'b0, '0, 0, 0, 0, -1, 1'b0, tx, dc, ob, bb);
        checks++; if (tx !== 48'h400000000095) begin errors++; $display("FAIL cmd0_frame got %h exp 400000000095", tx); end
        checks++; if (dc !== 57) begin errors++; $display("FAIL cmd0_done got %0d exp 57", dc); end
        checks++; if ({ob, bb} !== 2'b00) begin errors++; $display("FAIL cmd0_oe_busy got %b exp 00", {ob, bb}); end
        checks++; if (flg !== 4'b0000) begin errors++; $display("FAIL cmd0_flags got %b exp 0000", flg); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL cmd0_done_pulse got %b exp 0", done); end
    endtask

    task automatic test_short();
        logic [47:0] tx; int dc; logic ob, bb;
        do_cmd(6'd8, 32'h1AA, 2'b01, 1'b1, 1'b0, 136'h08000001AA13, 48, 3, 0, -1, 1'b0, tx, dc, ob, bb);
        checks++; if (tx !== 48'h48000001AA87) begin errors++; $display("FAIL cmd8_frame got %h exp 48000001AA87", tx); end
        checks++; if (dc !== 60 + 48) begin errors++; $display("FAIL cmd8_done got %0d exp 108", dc); end
        checks++; if (resp !== 128'h1AA) begin errors++; $display("FAIL cmd8_resp got %h exp 1aa", resp); end
        checks++; if (resp_index !== 6'd8) begin errors++; $display("FAIL cmd8_index got %0d exp 8", resp_index); end
        checks++; if (flg !== 4'b0000) begin errors++; $display("FAIL cmd8_flags got %b exp 0000", flg); end
    endtask

    task automatic test_crc_index();
        logic [47:0] tx; int dc; logic ob, bb;
        do_cmd(6'd8, 32'h1AA, 2'b01, 1'b0, 1'b0, 136'h08000001AA15, 48, 3, 0, -1, 1'b0, tx, dc, ob, bb);
        checks++; if (flg !== 4'b0100) begin errors++; $display("FAIL bad_crc_flags got %b exp 0100", flg); end
        do_cmd(6'd8, 32'h1AA, 2'b11, 1'b0, 1'b0, 136'h08000001AA15, 48, 3, 0, -1, 1'b0, tx, dc, ob, bb);
        checks++; if (flg !== 4'b0000) begin errors++; $display("FAIL r3_nocrc_flags got %b exp 0000", flg); end
        do_cmd(6'd8, 32'h1AA, 2'b11, 1'b0, 1'b0, 136'h08000001AA12, 48, 3, 0, -1, 1'b0, tx, dc, ob, bb);
        checks++; if (f_crc_fail !== 1'b1) begin errors++; $display("FAIL end_bit_zero got %b exp 1", f_crc_fail); end
        do_cmd(6'd8, 32'h1AA, 2'b01, 1'b1, 1'b0, 136'h09000001AA13, 48, 3, 0, -1, 1'b0, tx, dc, ob, bb);
        checks++; if (f_index_fail !== 1'b1 || resp_index !== 6'd9) begin errors++; $display("FAIL index_mismatch got %b/%0d exp 1/9", f_index_fail, resp_index); end
        do_cmd(6'd8, 32'h1AA, 2'b01, 1'b0, 1'b0, 136'h09000001AA13, 48, 3, 0, -1, 1'b0, tx, dc, ob, bb);
        checks++; if (f_index_fail !== 1'b0) begin errors++; $display("FAIL index_unchecked got %b exp 0", f_index_fail); end
    endtask

    task automatic test_timeout();
        logic [47:0] tx; int dc; logic ob, bb;
        do_cmd(6'd13, 32'h0, 2'b01, 1'b0, 1'b0, '0, 0, 0, 0, -1, 1'b0, tx, dc, ob, bb);
        checks++; if (dc !== 57 + 64) begin errors++; $display("FAIL timeout_done got %0d exp 121", dc); end
        checks++; if (flg !== 4'b1000) begin errors++; $display("FAIL timeout_flags got %b exp 1000", flg); end
        checks++; if (resp !== 128'h1AA || resp_index !== 6'd9) begin errors++; $display("FAIL timeout_resp_kept got %h/%0d exp 1aa/9", resp, resp_index); end
    endtask

    task automatic test_long();
        logic [47:0] tx; int dc; logic ob, bb;
        logic [119:0] data;
        logic [6:0] c;
        logic [135:0] rep;
        data = 120'h0123456789ABCDEFFEDCBA98765432;
        c = crc7(data, 120);
        rep = {8'h3F, data, c, 1'b1};
        do_cmd(6'd2, 32'h0, 2'b10, 1'b0, 1'b0, rep, 136, 0, 0, -1, 1'b0, tx, dc, ob, bb);
        checks++; if (dc !== 57 + 136) begin errors++; $display("FAIL long_done got %0d exp 193", dc); end
        checks++; if (resp !== {data, c, 1'b1}) begin errors++; $display("FAIL long_resp got %h exp %h", resp, {data, c, 1'b1}); end
        checks++; if (flg !== 4'b0000) begin errors++; $display("FAIL long_flags got %b exp 0000", flg); end
        rep[60] = ~rep[60];
        do_cmd(6'd2, 32'h0, 2'b10, 1'b0, 1'b0, rep, 136, 0, 0, -1, 1'b0, tx, dc, ob, bb);
        checks++; if (flg !== 4'b0100) begin errors++; $display("FAIL long_bad_crc got %b exp 0100", flg); end
    endtask

    task automatic test_busy();
        logic [47:0] tx; int dc; logic ob, bb;
        logic [39:0] hdr;
        logic [135:0] rep;
        hdr = {2'b00, 6'd7, 32'h00000900};
        rep = {88'h0, hdr, crc7(120'(hdr), 40), 1'b1};
        // S = 57+2 = 59; dat0 high from S+148, done one cycle later.
        do_cmd(6'd7, 32'h0, 2'b01, 1'b0, 1'b1, rep, 48, 2, 100, -1, 1'b0, tx, dc, ob, bb);
        checks++; if (dc !== 59 + 149) begin errors++; $display("FAIL busy_done got %0d exp 208", dc); end
        checks++; if (flg !== 4'b0000 || resp !== 128'h900) begin errors++; $display("FAIL busy_flags_resp got %b/%h exp 0000/900", flg, resp); end
        // dat0 already high during the blanking window: first usable sample S+50.
        do_cmd(6'd7, 32'h0, 2'b01, 1'b0, 1'b1, rep, 48, 2, 0, -1, 1'b0, tx, dc, ob, bb);
        checks++; if (dc !== 59 + 51) begin errors++; $display("FAIL busy_blank_done got %0d exp 110", dc); end
    endtask

    task automatic test_busy_timeout();
        logic [47:0] tx; int dc; logic ob, bb;
        logic [39:0] hdr;
        logic [135:0] rep;
        int w;
        hdr = {2'b00, 6'd7, 32'h00000900};
        rep = {88'h0, hdr, crc7(120'(hdr), 40), 1'b1};
        do_cmd(6'd7, 32'h0, 2'b01, 1'b0, 1'b1, rep, 48, 2, -1, -1, 1'b1, tx, dc, ob, bb);
        checks++; if (dc !== 59 + 66) begin errors++; $display("FAIL busy_to_done got %0d exp 125", dc); end
        checks++; if (bt_f_busy_timeout !== 1'b1) begin errors++; $display("FAIL busy_to_flag got %b exp 1", bt_f_busy_timeout); end
        checks++; if (busy !== 1'b1 || f_busy_timeout !== 1'b0) begin errors++; $display("FAIL busy_long_wait got %b/%b exp 1/0", busy, f_busy_timeout); end
        dat0_in = 1'b1;
        w = 0;
        while (!done && w < 10) begin tick(); w++; end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL busy_release got %b exp 1", done); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [47:0] tx; int dc; logic ob, bb;
        cmd_index = 6'd0; cmd_arg = 32'h0; resp_type = 2'b00; busy_chk = 1'b0; cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        repeat (N + 20) tick();
        checks++; if (cmd_oe !== 1'b1 || cmd_out !== 1'b0) begin errors++; $display("FAIL mid_send got %b/%b exp 1/0", cmd_oe, cmd_out); end
        #2 rst = 1'b1;
        #1;
        checks++; if (cmd_oe !== 1'b0 || cmd_out !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL async_rst got %b/%b/%b exp 0/1/0", cmd_oe, cmd_out, busy); end
        tick();
        rst = 1'b0;
        tick();
        do_cmd(6'd8, 32'h1AA, 2'b01, 1'b1, 1'b0, 136'h08000001AA13, 48, 3, 0, -1, 1'b0, tx, dc, ob, bb);
        checks++; if (dc !== 108 || flg !== 4'b0000 || resp !== 128'h1AA) begin errors++; $display("FAIL after_rst got %0d/%b/%h exp 108/0000/1aa", dc, flg, resp); end
    endtask

    task automatic test_ignore_busy();
        logic [47:0] tx; int dc; logic ob, bb;
        do_cmd(6'd0, 32'h0, 2'b00, 1'b0, 1'b0, '0, 0, 0, 0, 10, 1'b0, tx, dc, ob, bb);
        checks++; if (tx !== 48'h400000000095 || dc !== 57) begin errors++; $display("FAIL start_while_busy got %h/%0d exp 400000000095/57", tx, dc); end
    endtask

    task automatic test_back_to_back();
        logic [47:0] tx; int dc; logic ob, bb;
        do_cmd(6'd0, 32'h0, 2'b00, 1'b0, 1'b0, '0, 0, 0, 0, -1, 1'b0, tx, dc, ob, bb);
        do_cmd(6'd55, 32'hDEADBEEF, 2'b00, 1'b0, 1'b0, '0, 0, 0, 0, -1, 1'b0, tx, dc, ob, bb);
        checks++; if (dc !== 57 || tx[47:8] !== {2'b01, 6'd55, 32'hDEADBEEF} || tx[0] !== 1'b1) begin errors++; $display("FAIL back_to_back got %h/%0d exp %h../57", tx, dc, {2'b01, 6'd55, 32'hDEADBEEF}); end
    endtask

    initial begin
        test_reset();
        test_no_resp();
        test_short();
        test_crc_index();
        test_timeout();
        test_long();
        test_busy();
        test_busy_timeout();
        test_reset_mid();
        test_ignore_busy();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_cmd_engine.md
# sd_cmd_engine

Parametrised SD/SDIO command-line engine; successor to the fixed-timing command path state machine. It serialises a 48-bit command frame with CRC7 onto the CMD line, then optionally receives a short (48-bit) or long (136-bit) response. Response handling covers optional CRC bypass (R3), command-index checking and R1b busy wait on DAT0. It sits between the register/CPSM front end and the SD pad ring, and reports sticky status flags plus a one-cycle completion pulse.

## Interface
- IDLE_CYCLES, 8, clocks of CMD hi-Z (Ncc gap) before each frame; ≥1
- RESP_TIMEOUT, 64, max clocks waiting for a response start bit (Ncr); ≥2
- BUSY_TIMEOUT, 65535, max clocks waiting for DAT0 release in busy mode
- sd_clk  in  1  SD clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_start  in  1  start pulse; accepted only while busy=0
- cmd_index  in  6  command index; sampled with cmd_start
- cmd_arg  in  32  argument; sampled with cmd_start
- resp_type  in  2  00 none, 01 short, 10 long, 11 short without CRC check; sampled with cmd_start
- chk_index  in  1  short responses only: flag mismatch between response index and cmd_index
- busy_chk  in  1  after a short response, wait for DAT0 high
- dat0_in  in  1  DAT0 line, used for busy detect
- cmd_in  in  1  CMD line input
- cmd_oe  out  1  CMD output enable
- cmd_out  out  1  CMD output data
- busy  out  1  engine active
- done  out  1  one-cycle completion pulse
- resp_index  out  6  received frame bits [45:40]
- resp  out  128  short: {96'b0, frame[39:8]}; long: frame[127:0]
- f_timeout, f_crc_fail, f_index_fail, f_busy_timeout  out  1 each  sticky error flags

## Operation
- States: IDLE, GAP, SEND, WAIT_RSP, RECV, BUSY, DONE.
- IDLE: cmd_start=1 latches all inputs, clears all four flags, and moves to GAP. cmd_start while busy=1 is ignored.
- GAP: cmd_oe=0 for IDLE_CYCLES cycles, then SEND.
- SEND: 48 bits, MSB first: 0, 1, index[5:0], arg[31:0], CRC7, 1.
  - CRC7 uses polynomial x^7+x^3+1, init 0, over the first 40 bits.
  - After the end bit: resp_type=00 goes to DONE; otherwise WAIT_RSP.
- WAIT_RSP: cmd_oe=0; counts clocks.
  - cmd_in sampled 0 goes to RECV; that bit is frame bit 47.
  - If the count reaches RESP_TIMEOUT, set f_timeout and go to DONE.
- RECV: shift in the remaining 47 bits (short) or 135 bits (long).
  - CRC span: short uses frame[47:8]; long uses frame[127:8]. Compare against frame[7:1].
  - f_crc_fail is set on CRC mismatch (suppressed for type 11) or on end bit = 0.
  - f_index_fail is set only if chk_index=1, the type is short, and resp_index≠cmd_index.
  - resp and resp_index update on the end-bit edge.
- BUSY is entered only for short responses with busy_chk=1.
  - DAT0 is ignored for the first 2 cycles after the end bit.
  - The first dat0_in=1 sample goes to DONE.
  - Reaching BUSY_TIMEOUT sets f_busy_timeout and goes to DONE.
- DONE: done=1 and busy=0 in the same cycle; next state is IDLE.
- The response path continues after errors; flags do not abort it (timeout excepted).

## Timing
- Reset values: cmd_oe=0, cmd_out=1, busy=0, done=0, resp=0, resp_index=0, all flags 0, state IDLE.
- Reset is asynchronous. Asserted mid-frame, it releases CMD (cmd_oe=0) immediately.
- All outputs are registered. Cycle 0 is the cycle in which cmd_start is sampled.
  - busy=1 from cycle 1.
  - GAP occupies cycles 1..N, where N=IDLE_CYCLES.
  - Frame bit 47-k is on cmd_out in cycle N+1+k; cmd_oe=1 for cycles N+1..N+48.
- No response: done in cycle N+49.
- Response wait: counting starts in cycle N+49 with cmd_oe=0. The CMD line is thus released 1 cycle after the end bit; Ncr counts from there.
- If the start bit is sampled in cycle S: the end bit is at S+47 (short) or S+135 (long); done is at S+48 or S+136.
- Busy: dat0 sampling starts at S+50. If dat0=1 is first seen at cycle B, done is at B+1.
- A new cmd_start is accepted in the cycle after done.
- cmd_in and dat0_in are sampled directly. No extra synchroniser stage inside this block.

## Test plan
- CMD0, arg 0, type 00, N=8 -> cmd_out bits in cycles 9..56 = 0x400000000095; done in cycle 57; no flags set.
- CMD8, arg 0x1AA, type 01 -> frame 0x48000001AA87. Card replies 0x08000001AA13 starting 3 cycles after release -> resp[31:0]=0x000001AA, resp_index=8, no flags, done at S+48.
- Same as the CMD8 case, but the reply CRC byte is 0x15 -> f_crc_fail=1. Same reply with type 11 -> no flag. Reply index 9 with chk_index=1 -> f_index_fail=1.
- Type 01, cmd_in held high, RESP_TIMEOUT=64 -> f_timeout=1; done 64 cycles after release; resp unchanged.
- Type 10, 136-bit reply with valid CRC -> resp = frame[127:0], done at S+136. busy_chk=1 with a short reply and dat0 low for 100 cycles -> done 1 cycle after dat0 goes high. dat0 stuck low with BUSY_TIMEOUT=16 -> f_busy_timeout=1.
- rst pulsed during SEND bit 20 -> cmd_oe=0 and cmd_out=1 immediately. A following command completes normally. cmd_start asserted while busy -> ignored.
